// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx_pkg
// Description : Shared types and constants for the memory-mapped UART
//               transmitter. These include the IO write-control bundle from
//               the data memory decode, register offsets, status bit indices
//               and the serialiser state encoding.
//               Build option: MMIO_UART_TX_PARITY_EN adds a PARITY state.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_tx_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } write_width_t;

    typedef struct packed {
        logic               enable;
        logic [XLEN-1:0]    addr;
        logic [XLEN-1:0]    value;
        write_width_t       width;
    } mem_write_control_t;

    localparam logic [XLEN-1:0] UART_TX_DATA_OFFSET = 32'd0;
    localparam logic [XLEN-1:0] UART_STATUS_OFFSET  = 32'd4;

    // Status register bit positions
    localparam int UART_STATUS_EMPTY = 0;
    localparam int UART_STATUS_FULL  = 1;
    localparam int UART_STATUS_IDLE  = 2;

    typedef enum logic [2:0] {
        UART_ST_IDLE   = 3'd0,
        UART_ST_START  = 3'd1,
        UART_ST_DATA   = 3'd2,
`ifdef MMIO_UART_TX_PARITY_EN
        UART_ST_PARITY = 3'd4,
`endif
        UART_ST_STOP   = 3'd3
    } uart_tx_state_t;

endpackage : mmio_uart_tx_pkg
`default_nettype wire

// File: rtl/mmio_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mmio_tx_fifo
// Description : Synchronous byte FIFO with first-word-fall-through read data.
//               A push into a full FIFO is ignored, and so is a pop from an
//               empty FIFO.
// Ports       : clock, reset        - clock and synchronous active-high reset
//               push, data_in       - write strobe and byte
//               pop, data_out       - read strobe and head byte (valid if !empty)
//               empty, full, count  - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_tx_fifo #(
    parameter int DEPTH = 4     // power of 2, at least 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               data_in,
    output logic [7:0]               data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [7:0]           r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign count     = r_count;
    assign data_out  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= data_in;
    end

endmodule : mmio_tx_fifo
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped UART transmitter. IO writes to BASE_ADDR queue a
//               byte, and writes to other addresses are acknowledged with no
//               effect. BASE_ADDR+4 reads back {idle, full, empty}. Bytes are
//               sent LSB first as 8N1 frames. When MMIO_UART_TX_PARITY_EN is
//               defined, an even parity bit follows the data bits.
// Ports       : clock, reset     - clock and synchronous active-high reset
//               write_control    - IO write request from the data memory decode
//               read_addr        - IO read address
//               write_complete   - one-cycle acknowledge of an accepted write
//               r_data           - IO read data (combinational)
//               tx               - serial line, idles high
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR    = 32'h0003_0000,
    parameter int              CLKS_PER_BIT = 16,   // at least 2
    parameter int              FIFO_DEPTH   = 4     // power of 2, at least 2
) (
    input  logic                clock,
    input  logic                reset,
    input  mem_write_control_t  write_control,
    input  logic [XLEN-1:0]     read_addr,
    output logic                write_complete,
    output logic [XLEN-1:0]     r_data,
    output logic                tx
);

    localparam int                   c_baud_w      = $clog2(CLKS_PER_BIT);
    localparam int                   c_cnt_w       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_baud_w-1:0]  c_baud_max    = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0]   c_depth       = c_cnt_w'(FIFO_DEPTH);
    localparam logic [XLEN-1:0]      c_data_addr   = BASE_ADDR + UART_TX_DATA_OFFSET;
    localparam logic [XLEN-1:0]      c_status_addr = BASE_ADDR + UART_STATUS_OFFSET;

    // ------------------------------------------------------------------
    // Write acceptance: the hart holds enable until it sees write_complete,
    // so r_ack_pending masks the request during the acknowledge cycle.
    // ------------------------------------------------------------------
    logic                r_ack_pending;
    logic                w_is_data_wr;
    logic                w_accept;
    logic                w_fifo_push;
    logic                w_fifo_pop;
    logic [7:0]          w_fifo_data;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [c_cnt_w-1:0]  w_fifo_count;
    logic                w_unused;

    assign w_is_data_wr = (write_control.addr == c_data_addr);
    assign w_accept     = write_control.enable && !r_ack_pending &&
                          (!w_is_data_wr || (w_fifo_count < c_depth));
    assign w_fifo_push  = w_accept && w_is_data_wr;
    assign w_unused     = ^{write_control.value[XLEN-1:8], write_control.width};

    always_ff @(posedge clock) begin
        if (reset) r_ack_pending <= 1'b0;
        else       r_ack_pending <= w_accept;
    end

    assign write_complete = r_ack_pending;

    mmio_tx_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (w_fifo_push),
        .pop      (w_fifo_pop),
        .data_in  (write_control.value[7:0]),
        .data_out (w_fifo_data),
        .empty    (w_fifo_empty),
        .full     (w_fifo_full),
        .count    (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    uart_tx_state_t       r_state,   w_state_nxt;
    logic [c_baud_w-1:0]  r_baud,    w_baud_nxt;
    logic [2:0]           r_bit_idx, w_bit_idx_nxt;
    logic [7:0]           r_shift,   w_shift_nxt;
    logic                 w_load;
    logic                 w_tx;
`ifdef MMIO_UART_TX_PARITY_EN
    logic                 r_parity,  w_parity_nxt;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= UART_ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
`ifdef MMIO_UART_TX_PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_load        = 1'b0;
        w_tx          = 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
        w_parity_nxt  = r_parity;
`endif
        case (r_state)
            UART_ST_IDLE: begin
                w_load = !w_fifo_empty;
            end
            UART_ST_START: begin
                w_tx = 1'b0;
                if (r_baud == '0) begin
                    w_state_nxt   = UART_ST_DATA;
                    w_baud_nxt    = c_baud_max;
                    w_bit_idx_nxt = '0;
                end else begin
                    w_baud_nxt = r_baud - 1'b1;
                end
            end
            UART_ST_DATA: begin
                w_tx = r_shift[0];
                if (r_baud == '0) begin
                    w_baud_nxt  = c_baud_max;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        w_state_nxt = UART_ST_PARITY;
`else
                        w_state_nxt = UART_ST_STOP;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud - 1'b1;
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            UART_ST_PARITY: begin
                w_tx = r_parity;
                if (r_baud == '0) begin
                    w_state_nxt = UART_ST_STOP;
                    w_baud_nxt  = c_baud_max;
                end else begin
                    w_baud_nxt = r_baud - 1'b1;
                end
            end
`endif
            UART_ST_STOP: begin
                w_tx = 1'b1;
                if (r_baud == '0) begin
                    // Chain straight into the next frame when one is queued
                    // so that back-to-back frames have no idle gap.
                    if (!w_fifo_empty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = UART_ST_IDLE;
                        w_baud_nxt  = '0;
                    end
                end else begin
                    w_baud_nxt = r_baud - 1'b1;
                end
            end
            default: begin
                w_state_nxt = UART_ST_IDLE;
                w_baud_nxt  = '0;
            end
        endcase

        if (w_load) begin
            w_state_nxt   = UART_ST_START;
            w_baud_nxt    = c_baud_max;
            w_bit_idx_nxt = '0;
            w_shift_nxt   = w_fifo_data;
`ifdef MMIO_UART_TX_PARITY_EN
            w_parity_nxt  = ^w_fifo_data;
`endif
        end
    end

    assign w_fifo_pop = w_load;
    assign tx         = w_tx;

    // ------------------------------------------------------------------
    // Status read
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_status;

    always_comb begin
        w_status                    = '0;
        w_status[UART_STATUS_EMPTY] = w_fifo_empty;
        w_status[UART_STATUS_FULL]  = w_fifo_full;
        w_status[UART_STATUS_IDLE]  = (r_state == UART_ST_IDLE) && w_fifo_empty;
        r_data = (read_addr == c_status_addr) ? w_status : '0;
    end

endmodule : mmio_uart_tx
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4,
//               FIFO_DEPTH=4). A queue/timeline model predicts tx,
//               write_complete and r_data on every cycle. Directed literal
//               checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0003_0000;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          FB    = 11;
    localparam logic [10:0] A5_FRAME = 11'b1_0_1010_0101_0;
`else
    localparam int          FB    = 10;
    localparam logic [10:0] A5_FRAME = 11'b0_1_1010_0101_0;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    mem_write_control_t wc;
    logic [31:0]        read_addr;
    logic               write_complete;
    logic [31:0]        r_data;
    logic               tx;

    always #5 clock = ~clock;

    mmio_uart_tx #(
        .BASE_ADDR      (BASE),
        .CLKS_PER_BIT   (CPB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .write_control  (wc),
        .read_addr      (read_addr),
        .write_complete (write_complete),
        .r_data         (r_data),
        .tx             (tx)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
`ifdef MMIO_UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b11, b, 1'b0};
`endif
    endfunction

    // ------------------------------------------------------------------
    // Reference model: byte queue plus a frame timeline
    // ------------------------------------------------------------------
    logic [7:0]  q[$];
    int          cyc    = 0;
    int          fstart = -1000;
    logic [10:0] fbits  = '1;
    bit          ack_p  = 1'b0;
    bit          mvalid = 1'b0;

    always @(negedge clock) begin : model
        bit          in_fr;
        logic        exp_tx;
        logic [31:0] st;
        int          cnt;
        bit          acc;

        in_fr = (cyc >= fstart) && (cyc < fstart + FB * CPB);
        if (mvalid) begin
            exp_tx = in_fr ? fbits[(cyc - fstart) / CPB] : 1'b1;
            st     = {29'b0, (!in_fr && q.size() == 0), (q.size() == DEPTH), (q.size() == 0)};
            check("tx", {31'b0, tx}, {31'b0, exp_tx});
            check("write_complete", {31'b0, write_complete}, {31'b0, ack_p});
            check("r_data", r_data, (read_addr == BASE + 32'd4) ? st : 32'd0);
        end

        if (reset) begin
            q.delete();
            fstart = -1000;
            ack_p  = 1'b0;
            mvalid = 1'b1;
        end else begin
            cnt = q.size();
            acc = wc.enable && !ack_p && ((wc.addr != BASE) || (cnt < DEPTH));
            // Serialiser can take a byte when idle or in its last stop cycle
            if ((cyc >= fstart + FB * CPB - 1) && (cnt > 0)) begin
                fbits  = mk_frame(q.pop_front());
                fstart = cyc + 1;
            end
            if (acc && wc.addr == BASE) q.push_back(wc.value[7:0]);
            ack_p = acc;
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] val,
                            input write_width_t width, output int lat);
        wc.enable = 1'b1;
        wc.addr   = addr;
        wc.value  = val;
        wc.width  = width;
        for (lat = 1; lat <= 300; lat++) begin
            @(posedge clock); #1;
            if (write_complete === 1'b1) break;
        end
        wc.enable = 1'b0;
        if (lat > 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack after %0d cycles, required ack", lat - 1);
        end
    endtask

    initial begin
        int lat;
        int lats[6];
        int gap;

        wc        = '0;
        read_addr = BASE + 32'd4;
        reset     = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Quiet period after reset
        repeat (20) @(posedge clock);
        #1;
        check("status_after_reset", r_data, 32'h5);
        check("tx_idle_after_reset", {31'b0, tx}, 32'd1);

        // Single byte 0xA5
        do_write(BASE, 32'h0000_00A5, WIDTH_WORD, lat);
        check("ack_latency_a5", lat, 1);
        @(posedge clock); #1;
        check("ack_single_cycle", {31'b0, write_complete}, 32'd0);
        @(posedge clock); #1;
        for (int i = 0; i < FB; i++) begin
            check("tx_a5_bit", {31'b0, tx}, {31'b0, A5_FRAME[i]});
            repeat (4) @(posedge clock);
            #1;
        end
        check("status_after_a5", r_data, 32'h5);

        // Six back-to-back bytes: the sixth waits for a free slot
        for (int i = 0; i < 6; i++) begin
            do_write(BASE, 32'(i + 1), WIDTH_BYTE, lats[i]);
        end
        check("second_ack_latency", lats[1], 2);
        check("sixth_ack_withheld", {31'b0, (lats[5] > 2)}, 32'd1);
        repeat (6 * FB * CPB + 10) @(posedge clock);
        #1;
        check("status_after_burst", r_data, 32'h5);

        // Non-data address: acknowledged without side effect
        do_write(BASE + 32'd8, 32'h0000_00FF, WIDTH_BYTE, lat);
        check("ack_latency_other_addr", lat, 1);
        @(posedge clock); #1;
        check("status_after_other_addr", r_data, 32'h5);

        // Reset in the middle of a frame
        do_write(BASE, 32'h0000_003C, WIDTH_WORD, lat);
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("tx_after_midframe_reset", {31'b0, tx}, 32'd1);
        check("status_after_midframe_reset", r_data, 32'h5);
        repeat (50) @(posedge clock);
        #1;

`ifdef MMIO_UART_TX_PARITY_EN
        // 0x07 has three set bits, so even parity is 1
        do_write(BASE, 32'h0000_0007, WIDTH_WORD, lat);
        repeat (38) @(posedge clock);
        #1;
        check("parity_bit_07", {31'b0, tx}, 32'd1);
        repeat (20) @(posedge clock);
        #1;
`endif

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            gap = $urandom_range(0, 20);
            for (int g = 0; g < gap; g++) begin
                case ($urandom_range(0, 2))
                    0:       read_addr = BASE + 32'd4;
                    1:       read_addr = BASE;
                    default: read_addr = $urandom;
                endcase
                @(posedge clock); #1;
            end
            case ($urandom_range(0, 3))
                0, 1:    do_write(BASE, $urandom, write_width_t'($urandom_range(0, 2)), lat);
                2:       do_write(BASE + 32'd8, $urandom, write_width_t'($urandom_range(0, 2)), lat);
                default: do_write(BASE + 32'd4, $urandom, write_width_t'($urandom_range(0, 2)), lat);
            endcase
        end
        read_addr = BASE + 32'd4;
        repeat (DEPTH * FB * CPB + 60) @(posedge clock);
        #1;
        check("status_after_random", r_data, 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mmio_uart_tx
`default_nettype wire

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that sits directly downstream of the hart's memory-mapped IO port. It consumes the `mem_write_control_t` produced by the data memory's IO decode and returns `write_complete`, which releases the hart's WRITEBACK stage. It also supplies `memory_mapped_io_r_data`. Bytes are buffered in a small FIFO and serialised as 8N1 frames on `tx`.

Parameters:
- BASE_ADDR, 32'h00030000: byte address of the TX data register. The status register is at BASE_ADDR+4.
- CLKS_PER_BIT, 16: clock cycles per UART bit. Must be at least 2.
- FIFO_DEPTH, 4: TX FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clock, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- write_control, in, mem_write_control_t: fields enable, addr, value, width from the data memory IO decode.
- read_addr, in, XLEN: address of the current IO read.
- write_complete, out, 1: one-cycle acknowledge of the accepted write.
- r_data, out, XLEN: IO read data.
- tx, out, 1: serial line; idles high.

Behaviour:
- Reset values:
  - tx=1, write_complete=0.
  - FIFO empty, serialiser in IDLE, baud and bit counters 0.
  - Reset mid-frame drives tx high on the next edge. A pending unacknowledged write is dropped.
- Write acceptance:
  - A write is accepted in cycle N when write_control.enable=1, ack_pending=0, and the write is either not to BASE_ADDR or the FIFO count < FIFO_DEPTH. Count is evaluated before this cycle's pop.
  - write_complete=1 in cycle N+1 for exactly one cycle (registered). ack_pending blocks acceptance during that cycle.
  - This gives exactly one acceptance per hart WRITEBACK, even though enable stays high until the hart advances.
- Write decode:
  - A write to BASE_ADDR pushes value[7:0]. All write_width_t values are treated alike; the upper bits are ignored.
  - A write to any other address is accepted and acknowledged with no side effect.
- FIFO full: the write is not accepted and write_complete stays 0, so the hart stalls. Acceptance happens on the first cycle count < FIFO_DEPTH.
- Simultaneous push and pop: both take effect and the count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Reads (combinational, no side effects):
  - read_addr=BASE_ADDR+4 → r_data = {29'b0, idle, full, empty}.
  - idle = serialiser IDLE and FIFO empty.
  - Any other read_addr → r_data = 0.
- Serialiser FSM, with states IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is not empty, pop the head into shift_reg, load the baud counter with CLKS_PER_BIT-1, and go to START. tx=1.
  - START: tx=0.
  - DATA: tx=shift_reg[0], LSB first. Shift on each bit boundary; bit_idx counts 0..7.
  - STOP: tx=1.
  - Every bit lasts exactly CLKS_PER_BIT cycles. The baud counter decrements, and at 0 the FSM advances and reloads.
  - After STOP, go to IDLE. An IDLE with a non-empty FIFO pops in the same cycle, so back-to-back frames have no extra idle cycles; frame period is 10*CLKS_PER_BIT.
  - The first START cycle is the cycle after the pop.
- Width rules:
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - Count width is $clog2(FIFO_DEPTH)+1.

Optional Feature:
- Macro MMIO_UART_TX_PARITY_EN.
- When defined: a PARITY state sits between DATA and STOP and drives even parity, the XOR of the 8 data bits. Frame is 11 bits, period 11*CLKS_PER_BIT.
- When undefined: no PARITY state or logic; 8N1 framing.

Decomposition:
- Shared package (with mem_write_control_t, write_width_t, XLEN):
  - UART_TX_DATA_OFFSET=0 and UART_STATUS_OFFSET=4.
  - uart_tx_state_t enum.
  - UART status bit indices: EMPTY=0, FULL=1, IDLE=2.
- One sub-module, mmio_tx_fifo: synchronous FIFO with 8-bit data, parameter DEPTH, ports push/pop/data_in/data_out/empty/full/count. Read data is first-word-fall-through.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then hold enable low for 20 cycles → tx=1, write_complete never 1, status read = 32'h5.
- Write 0xA5 to BASE_ADDR with enable held until ack → write_complete is high exactly one cycle, one cycle after enable rises.
  - tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit lasting 4 cycles.
  - Status returns to 32'h5 after 40 cycles.
- Six back-to-back writes 0x01..0x06 → the 6th write's ack is withheld until a slot frees.
  - All six frames appear in order, contiguous, with no extra idle cycles between stop and start.
- Write 0xFF to BASE_ADDR+8, width byte → acked in 1 cycle, tx stays 1, FIFO empty.
- Assert reset at cycle 10 of a 0x3C frame → tx=1 on the next edge, status=32'h5, no further frame bits.
- With MMIO_UART_TX_PARITY_EN defined, write 0x07 → a parity bit of 1 follows the data bits; frame is 44 cycles.
